// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//
// Front-end sequencing stage of the 10-bit processor. It turns the raw
// execute push-button into a single-cycle step strobe and, on each step,
// advances the 2-bit timestep counter and optionally loads the instruction
// register from the shared bus. The controller's IRin / Clr outputs come
// back in here and only matter in the step cycle.
//
// Build option:
//   INSTR_SEQ_DEBOUNCE_EN defined   -> full debounce FSM (DBNC_CYCLES used)
//   INSTR_SEQ_DEBOUNCE_EN undefined -> step is the registered rising edge of
//                                      the synchronized button, no debounce
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   exec_btn  in   raw execute button (asynchronous to clk)
//   bus       in   shared data bus, IR load source
//   IRin      in   load INST from bus at the next step
//   Clr       in   return T to 0 at the next step
//   INST      out  instruction register
//   T         out  current timestep
//   step      out  one-cycle strobe, high in the cycle before T/INST update
// ---------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int DBNC_CYCLES = 4,
    parameter int WIDTH       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec_btn,
    input  logic [WIDTH-1:0] bus,
    input  logic             IRin,
    input  logic             Clr,
    output logic [WIDTH-1:0] INST,
    output logic [1:0]       T,
    output logic             step
);

    // Two-flop synchronizer; s_reg is the only view of the button.
    logic sync1_reg;
    logic s_reg;
    logic step_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            s_reg     <= 1'b0;
        end else begin
            sync1_reg <= exec_btn;
            s_reg     <= sync1_reg;
        end
    end

`ifdef INSTR_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DBNC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        HELD_HI,
        WAIT_LO
    } dbnc_state_t;

    dbnc_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             step_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE_LO;
            cnt_reg   <= '0;
            step_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            step_reg  <= step_next;
        end
    end

    // cnt counts consecutive samples that disagree with the accepted level;
    // the change is accepted on the sample that would make it DBNC_CYCLES.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        step_next  = 1'b0;
        case (state_reg)
            IDLE_LO: begin
                if (s_reg) begin
                    state_next = WAIT_HI;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (!s_reg) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HELD_HI;
                    cnt_next   = '0;
                    step_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HELD_HI: begin
                if (!s_reg) begin
                    state_next = WAIT_LO;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (s_reg) begin
                    state_next = HELD_HI;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
    end
`else
    // Fast build: every rising edge of s is a step, bounces included.
    logic s_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d_reg  <= 1'b0;
            step_reg <= 1'b0;
        end else begin
            s_d_reg  <= s_reg;
            step_reg <= s_reg & ~s_d_reg;
        end
    end

    // DBNC_CYCLES has no role in this build.
    logic dbnc_unused;
    assign dbnc_unused = (DBNC_CYCLES > 1);
`endif

    // Timestep / instruction register, touched only at the end of a step.
    logic [1:0]       t_reg;
    logic [WIDTH-1:0] inst_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg    <= 2'd0;
            inst_reg <= '0;
        end else if (step_reg) begin
            t_reg <= Clr ? 2'd0 : t_reg + 2'd1;
            if (IRin) begin
                inst_reg <= bus;
            end
        end
    end

    assign INST = inst_reg;
    assign T    = t_reg;
    assign step = step_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Self-checking bench for instruction_sequencer. A table of button presses
// with expected T/INST, hand-written sequences for latency, reset, bounce and
// out-of-step control inputs, then random button/control activity compared
// every cycle against a behavioural model of the block.
// ---------------------------------------------------------------------------
module tb_instruction_sequencer;

    localparam int DBNC = 4;
`ifdef INSTR_SEQ_DEBOUNCE_EN
    localparam bit DBNC_ON = 1'b1;
    localparam int LAT     = DBNC + 2;
`else
    localparam bit DBNC_ON = 1'b0;
    localparam int LAT     = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       exec_btn;
    logic [9:0] bus;
    logic       IRin;
    logic       Clr;
    logic [9:0] INST;
    logic [1:0] T;
    logic       step;

    instruction_sequencer #(.DBNC_CYCLES(DBNC), .WIDTH(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .exec_btn (exec_btn),
        .bus      (bus),
        .IRin     (IRin),
        .Clr      (Clr),
        .INST     (INST),
        .T        (T),
        .step     (step)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int step_seen = 0;

    // Behavioural model: button pipeline, accepted level with a run length
    // of disagreeing samples, and the architectural T/INST state.
    bit       m_sync1, m_s, m_s_d, m_level, m_step;
    int       m_run;
    bit [1:0] m_t;
    bit [9:0] m_inst;

    typedef struct {
        logic [9:0] bus;
        logic       irin;
        logic       clr;
        logic [1:0] exp_t;
        logic [9:0] exp_inst;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = 0; m_s = 0; m_s_d = 0; m_level = 0; m_step = 0;
        m_run = 0; m_t = 0; m_inst = 0;
    endtask

    task automatic model_edge();
        bit new_step;
        new_step = 1'b0;
        if (m_step) begin
            m_t = Clr ? 2'd0 : 2'((m_t + 1) % 4);
            if (IRin) m_inst = bus;
        end
        if (DBNC_ON) begin
            if (m_s != m_level) begin
                m_run++;
                if (m_run == DBNC) begin
                    m_level  = m_s;
                    m_run    = 0;
                    new_step = m_s;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            new_step = m_s && !m_s_d;
        end
        m_s_d   = m_s;
        m_step  = new_step;
        m_s     = m_sync1;
        m_sync1 = exec_btn;
    endtask

    // One clock: model advances on the rising edge, DUT checked on the falling.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        if (step === 1'b1) step_seen++;
        check("model_step", step, m_step);
        check("model_T",    T,    m_t);
        check("model_INST", INST, m_inst);
    endtask

    task automatic press(input logic [9:0] b, input logic ir, input logic c, input int len);
        bus = b; IRin = ir; Clr = c;
        exec_btn = 1'b1;
        repeat (len) cycle();
        exec_btn = 1'b0;
        repeat (14) cycle();
    endtask

    initial begin
        int       s0;
        bit [1:0] t_before;
        bit [9:0] i_before;

        vecs[0]  = '{10'h012, 1'b1, 1'b0, 2'd1, 10'h012};
        vecs[1]  = '{10'h3FF, 1'b0, 1'b0, 2'd2, 10'h012};
        vecs[2]  = '{10'h155, 1'b1, 1'b0, 2'd3, 10'h155};
        vecs[3]  = '{10'h0AA, 1'b0, 1'b0, 2'd0, 10'h155};
        vecs[4]  = '{10'h2A5, 1'b1, 1'b0, 2'd1, 10'h2A5};
        vecs[5]  = '{10'h000, 1'b0, 1'b0, 2'd2, 10'h2A5};
        vecs[6]  = '{10'h111, 1'b0, 1'b1, 2'd0, 10'h2A5};
        vecs[7]  = '{10'h0F0, 1'b0, 1'b0, 2'd1, 10'h2A5};
        vecs[8]  = '{10'h0F0, 1'b0, 1'b0, 2'd2, 10'h2A5};
        vecs[9]  = '{10'h0F0, 1'b0, 1'b0, 2'd3, 10'h2A5};
        vecs[10] = '{10'h3C3, 1'b1, 1'b1, 2'd0, 10'h3C3};

        rst = 1'b1; exec_btn = 1'b0; bus = '0; IRin = 1'b0; Clr = 1'b0;
        model_reset();
        repeat (2) cycle();
        check("reset_T",    T,    0);
        check("reset_INST", INST, 0);
        check("reset_step", step, 0);
        rst = 1'b0;
        repeat (4) cycle();

        // Table of presses
        for (int i = 0; i < 11; i++) begin
            s0 = step_seen;
            press(vecs[i].bus, vecs[i].irin, vecs[i].clr, 8);
            $display("[TB] press %0d: bus=%h IRin=%b Clr=%b -> T=%0d INST=%h", i,
                     vecs[i].bus, vecs[i].irin, vecs[i].clr, T, INST);
            check("tbl_T",     T,              vecs[i].exp_t);
            check("tbl_INST",  INST,           vecs[i].exp_inst);
            check("tbl_steps", step_seen - s0, 1);
        end

        // Asynchronous reset mid-cycle from T=2, INST=2A5
        press(10'h2A5, 1'b1, 1'b0, 8);
        press(10'h000, 1'b0, 1'b0, 8);
        check("pre_rst_T",    T,    2);
        check("pre_rst_INST", INST, 10'h2A5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_T",    T,    0);
        check("async_rst_INST", INST, 0);
        check("async_rst_step", step, 0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // Reset during qualification; held button counts as a new press
        exec_btn = 1'b1;
        repeat (2) cycle();
        #2 rst = 1'b1;
        #1;
        check("midop_rst_step", step, 0);
        model_reset();
        cycle();
        rst = 1'b0;
        s0 = step_seen;
        repeat (LAT + 3) cycle();
        check("midop_steps", step_seen - s0, 1);
        exec_btn = 1'b0;
        repeat (14) cycle();

        // Press latency: step high only after edge LAT, T moves after LAT+1
        t_before = m_t;
        exec_btn = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            cycle();
            check("lat_step", step, (k == LAT) ? 1 : 0);
        end
        check("lat_T", T, 2'(t_before + 1));
        exec_btn = 1'b0;
        repeat (14) cycle();

        // IRin/Clr asserted with no press: nothing changes
        t_before = m_t; i_before = m_inst;
        s0 = step_seen;
        IRin = 1'b1; Clr = 1'b1; bus = 10'h3FF;
        repeat (10) cycle();
        check("idle_T",     T,              t_before);
        check("idle_INST",  INST,           i_before);
        check("idle_steps", step_seen - s0, 0);
        IRin = 1'b0; Clr = 1'b0;

        // Two separated one-cycle glitches
        s0 = step_seen;
        exec_btn = 1'b1; cycle();
        exec_btn = 1'b0; repeat (6) cycle();
        exec_btn = 1'b1; cycle();
        exec_btn = 1'b0; repeat (14) cycle();
        check("glitch_steps", step_seen - s0, DBNC_ON ? 0 : 2);

        // Press bounce then release bounce
        s0 = step_seen;
        exec_btn = 1'b1; repeat (2) cycle();
        exec_btn = 1'b0; cycle();
        exec_btn = 1'b1; repeat (10) cycle();
        exec_btn = 1'b0; cycle();
        exec_btn = 1'b1; cycle();
        exec_btn = 1'b0; repeat (16) cycle();
        check("bounce_steps", step_seen - s0, DBNC_ON ? 1 : 3);

        // Random activity against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) exec_btn = ~exec_btn;
            IRin = 1'($urandom);
            Clr  = ($urandom_range(0, 3) == 0);
            bus  = 10'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
